// File: rtl/state_lasso_monitor.sv
// Lasso monitor for a free-running W-bit state stream: finds prefix length, cycle period
// and flags visits to state 0. Define LASSO_MON_CHECK_EN to enable immediate assertions.
module state_lasso_monitor #(
  parameter int unsigned W     = 5,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [W-1:0]     in_state,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [W-1:0]     repeat_state,
  output logic [CNT_W-1:0] prefix_len,
  output logic [CNT_W-1:0] period,
  output logic             zero_seen
);

  localparam int unsigned DEPTH = 2**W;

  if (CNT_W < W + 1) begin : g_bad_cnt_w
    $error("state_lasso_monitor: CNT_W must be >= W+1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE, OVF} state_t;

  state_t           state_q;
  logic [DEPTH-1:0] seen_q;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] stamp_q [DEPTH];

  logic             accept;
  logic             hit;
  logic [CNT_W-1:0] stamp_rd;

  always_comb begin
    accept   = (state_q == RUN) && in_valid && !start;
    hit      = seen_q[in_state];
    stamp_rd = stamp_q[in_state];
  end

  // Stamp table carries no reset; an entry is only read once its seen bit is set.
  always_ff @(posedge clk) begin
    if (accept && !hit) begin
      stamp_q[in_state] <= idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      seen_q       <= '0;
      idx_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      repeat_state <= '0;
      prefix_len   <= '0;
      period       <= '0;
      zero_seen    <= 1'b0;
    end else if (start) begin
      state_q      <= RUN;
      seen_q       <= '0;
      idx_q        <= '0;
      busy         <= 1'b1;
      done         <= 1'b0;
      overflow     <= 1'b0;
      repeat_state <= '0;
      prefix_len   <= '0;
      period       <= '0;
      zero_seen    <= 1'b0;
    end else if (accept) begin
      zero_seen <= zero_seen | (in_state == '0);
      if (hit) begin
        state_q      <= DONE;
        busy         <= 1'b0;
        done         <= 1'b1;
        repeat_state <= in_state;
        prefix_len   <= stamp_rd;
        period       <= idx_q - stamp_rd;
      end else begin
        seen_q[in_state] <= 1'b1;
        // Saturated index: hold it and park in OVF instead of wrapping.
        if (idx_q == '1) begin
          state_q  <= OVF;
          busy     <= 1'b0;
          overflow <= 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

`ifdef LASSO_MON_CHECK_EN
  always_comb begin
    if (rst_n) begin
      if (in_valid) begin
        assert (!$isunknown(in_state))
          else $error("state_lasso_monitor: in_state has X/Z while in_valid");
      end
      if (done) begin
        assert (period >= 1 && CNT_W'(prefix_len + period) == idx_q)
          else $error("state_lasso_monitor: inconsistent prefix_len/period");
      end
      assert (!(done && overflow))
        else $error("state_lasso_monitor: done and overflow both set");
    end
  end
`else
  // Assertions compiled out.
`endif

endmodule

// File: tb/tb_state_lasso_monitor.sv
// Directed table-driven bench for state_lasso_monitor with hand-computed expectations.
module tb_state_lasso_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [4:0] in_state;
  logic       busy, done, overflow, zero_seen;
  logic [4:0] repeat_state;
  logic [7:0] prefix_len, period;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  state_lasso_monitor #(.W(5), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_state     (in_state),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .repeat_state (repeat_state),
    .prefix_len   (prefix_len),
    .period       (period),
    .zero_seen    (zero_seen)
  );

  typedef struct {
    logic       st;
    logic       v;
    logic [4:0] s;
    logic       busy;
    logic       done;
    logic       zero;
    logic [4:0] rep;
    logic [7:0] pre;
    logic [7:0] per;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic v, logic [4:0] s, logic b, logic d,
                              logic z, logic [4:0] rep, logic [7:0] pre, logic [7:0] per);
    vec_t r;
    r.st = st; r.v = v; r.s = s; r.busy = b; r.done = d; r.zero = z;
    r.rep = rep; r.pre = pre; r.per = per;
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(string tag, vec_t e);
    chk({tag, ".busy"},         int'(busy),         int'(e.busy));
    chk({tag, ".done"},         int'(done),         int'(e.done));
    chk({tag, ".overflow"},     int'(overflow),     0);
    chk({tag, ".zero_seen"},    int'(zero_seen),    int'(e.zero));
    chk({tag, ".repeat_state"}, int'(repeat_state), int'(e.rep));
    chk({tag, ".prefix_len"},   int'(prefix_len),   int'(e.pre));
    chk({tag, ".period"},       int'(period),       int'(e.per));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic apply(string tag, vec_t e);
    start    = e.st;
    in_valid = e.v;
    in_state = e.s;
    @(posedge clk);
    #1;
    check_outs(tag, e);
    @(negedge clk);
  endtask

  task automatic feed(string tag, int n, int vals[$]);
    for (int i = 0; i < n; i++) begin
      apply($sformatf("%s[%0d]", tag, i), mk(1'b0, 1'b1, 5'(vals[i]), 1'b1, 1'b0, 1'b0, '0, '0, '0));
    end
  endtask

  vec_t zero_v;

  initial begin
    zero_v   = mk(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_state = '0;

    // Case 1: 27,22,13,28,19,6,13 -> repeat 13, prefix 2, period 4
    vecs.push_back(mk(1, 0, 0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 27, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 22, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 13, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 28, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 19, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 6,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 13, 0, 1, 0, 13, 2, 4));
    vecs.push_back(mk(0, 1, 0,  0, 1, 0, 13, 2, 4));
    vecs.push_back(mk(0, 0, 9,  0, 1, 0, 13, 2, 4));
    // Case 5: restart (sample in start cycle ignored), 1,2,1
    vecs.push_back(mk(1, 1, 13, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1,  0, 1, 0, 1, 0, 2));
    // No stale seen bits: 27 was seen in case 1
    vecs.push_back(mk(1, 0, 0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 27, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 28, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 27, 0, 1, 0, 27, 0, 2));
    // Case 2: 5,5 -> period 1
    vecs.push_back(mk(1, 0, 0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5,  0, 1, 0, 5, 0, 1));
    // Case 3: 0,3,0 -> zero_seen after first sample
    vecs.push_back(mk(1, 0, 0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0,  1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3,  1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0,  0, 1, 1, 0, 0, 2));
    // Case 4: gaps of 3 invalid cycles are not counted
    vecs.push_back(mk(1, 0, 0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 27, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 27, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 22, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 22, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 27, 0, 1, 0, 27, 0, 2));
    // start while in RUN restarts the run
    vecs.push_back(mk(1, 0, 0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 6,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 4,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 6,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 6,  0, 1, 0, 6, 0, 2));

    // Reset state, and in_valid ignored in IDLE
    repeat (2) @(negedge clk);
    #1;
    check_outs("reset", zero_v);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply("idle_ignore0", mk(0, 1, 0,  0, 0, 0, 0, 0, 0));
    apply("idle_ignore1", mk(0, 1, 17, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Case 6: async reset mid-run after 3 samples
    apply("c6_start", mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    feed("c6_feed", 3, '{7, 8, 9});
    rst_n = 1'b0;
    #1;
    check_outs("c6_async_rst", zero_v);
    @(negedge clk);
    rst_n = 1'b1;
    apply("c6_ignore0", mk(0, 1, 7, 0, 0, 0, 0, 0, 0));
    apply("c6_ignore1", mk(0, 1, 8, 0, 0, 0, 0, 0, 0));
    apply("c6_restart", mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    apply("c6_s0",      mk(0, 1, 8, 1, 0, 0, 0, 0, 0));
    apply("c6_s1",      mk(0, 1, 8, 0, 1, 0, 8, 0, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
